// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU unit.
// Optional early-out for |dividend| < |divisor| is enabled with DIV_EARLY_OUT_EN.
package div_unit_pkg;

  localparam int unsigned RegDataWidth = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface div_unit_if #(
  parameter int unsigned DATA_WIDTH = div_unit_pkg::RegDataWidth
);

  logic                  start;
  logic                  is_signed;
  logic                  cancel;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_by_zero;

  modport master (
    output start, is_signed, cancel, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, cancel, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_unit_sign_fix.sv
// Combinational sign handling: operand magnitudes at capture, result negation at completion.
module div_sign_fix
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RegDataWidth
) (
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] abs_a,
  output logic [DATA_WIDTH-1:0] abs_b,
  output logic                  neg_q,
  output logic                  neg_r,
  input  logic                  fix_q,
  input  logic                  fix_r,
  input  logic [DATA_WIDTH-1:0] q_raw,
  input  logic [DATA_WIDTH-1:0] r_raw,
  output logic [DATA_WIDTH-1:0] q_fix,
  output logic [DATA_WIDTH-1:0] r_fix
);

  logic a_neg;
  logic b_neg;

  always_comb begin
    a_neg = is_signed & a[DATA_WIDTH-1];
    b_neg = is_signed & b[DATA_WIDTH-1];
    abs_a = a_neg ? -a : a;
    abs_b = b_neg ? -b : b;
    neg_q = a_neg ^ b_neg;
    neg_r = a_neg;
    q_fix = fix_q ? -q_raw : q_raw;
    r_fix = fix_r ? -r_raw : r_raw;
  end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle; quotient -> LO, remainder -> HI.
// Define DIV_EARLY_OUT_EN to finish early when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RegDataWidth
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  localparam int unsigned         CntWidth = $clog2(DATA_WIDTH);
  localparam logic [CntWidth-1:0] CntLast  = CntWidth'(DATA_WIDTH - 1);

  div_state_e            state, state_next;
  logic [CntWidth-1:0]   cnt;
  logic [DATA_WIDTH:0]   rem_q;
  logic [DATA_WIDTH-1:0] q_work;
  logic [DATA_WIDTH-1:0] dvs;
  logic                  neg_q_q, neg_r_q, early_q;
  logic [DATA_WIDTH-1:0] quo_q, rem_out_q;
  logic                  dbz_q;

  logic [DATA_WIDTH-1:0] abs_a, abs_b;
  logic                  neg_q, neg_r;
  logic [DATA_WIDTH+1:0] shifted, diff;
  logic                  qbit;
  logic [DATA_WIDTH:0]   rem_step;
  logic [DATA_WIDTH-1:0] q_step;
  logic [DATA_WIDTH-1:0] q_raw, r_raw, q_fix, r_fix;
  logic                  fix_q;
  logic                  accept, last_iter, load_result, early_hit;
  logic                  busy, done;

  div_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_sign_fix (
    .is_signed (bus.is_signed),
    .a         (bus.dividend),
    .b         (bus.divisor),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .neg_q     (neg_q),
    .neg_r     (neg_r),
    .fix_q     (fix_q),
    .fix_r     (neg_r_q),
    .q_raw     (q_raw),
    .r_raw     (r_raw),
    .q_fix     (q_fix),
    .r_fix     (r_fix)
  );

`ifdef DIV_EARLY_OUT_EN
  assign early_hit = (abs_a < abs_b);
`else
  assign early_hit = 1'b0;
`endif

  assign accept      = (state == DivFree) && (bus.start == DivStart) && !bus.cancel;
  assign last_iter   = (cnt == CntLast);
  assign load_result = !bus.cancel &&
                       ((state == DivByZero) || ((state == DivOn) && last_iter));

  // q_work starts as |dividend| and shifts left, so its MSB is the next dividend bit.
  always_comb begin
    shifted  = {rem_q, q_work[DATA_WIDTH-1]};
    diff     = shifted - {2'b00, dvs};
    qbit     = ~diff[DATA_WIDTH+1];
    rem_step = qbit ? diff[DATA_WIDTH:0] : shifted[DATA_WIDTH:0];
    q_step   = {q_work[DATA_WIDTH-2:0], qbit};
  end

  // The short path reuses |dividend| still held in q_work; its sign fix restores the dividend.
  always_comb begin
    q_raw = q_step;
    r_raw = rem_step[DATA_WIDTH-1:0];
    fix_q = neg_q_q;
    if (state == DivByZero) begin
      q_raw = early_q ? '0 : '1;
      r_raw = q_work;
      fix_q = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = DivResultNotReady;
    case (state)
      DivFree: begin
        if (accept) begin
          state_next = ((bus.divisor == '0) || early_hit) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        busy       = 1'b1;
        state_next = bus.cancel ? DivFree : DivEnd;
      end
      DivOn: begin
        busy = 1'b1;
        if (bus.cancel) begin
          state_next = DivFree;
        end else if (last_iter) begin
          state_next = DivEnd;
        end
      end
      DivEnd: begin
        done       = DivResultReady;
        state_next = DivFree;
      end
      default: state_next = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= DivFree;
      cnt       <= '0;
      rem_q     <= '0;
      q_work    <= '0;
      dvs       <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      early_q   <= 1'b0;
      quo_q     <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        q_work  <= abs_a;
        dvs     <= abs_b;
        rem_q   <= '0;
        cnt     <= '0;
        neg_q_q <= neg_q;
        neg_r_q <= neg_r;
        early_q <= early_hit;
      end else if ((state == DivOn) && !bus.cancel) begin
        q_work <= q_step;
        rem_q  <= rem_step;
        cnt    <= cnt + 1'b1;
      end
      if (load_result) begin
        quo_q     <= q_fix;
        rem_out_q <= r_fix;
        dbz_q     <= (state == DivByZero) && !early_q;
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_out_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results, per-scenario tasks.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int unsigned W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  int           total = 0;
  int           bad = 0;
  exp_t         sb[$];
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_dbz = 1'b0;

  div_unit_if #(.DATA_WIDTH(W)) bus ();

  div_unit #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    logic [W-1:0] ma, mb;
    ma = (sgn && a[W-1]) ? -a : a;
    mb = (sgn && b[W-1]) ? -b : b;
    if (b == '0) return 2;
    if (EarlyEn && (ma < mb)) return 2;
    return 33;
  endfunction

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input int poke, input string name);
    exp_t e;
    int   busy_cnt;
    bit   seen;
    e.q = eq; e.r = er; e.dbz = edz; e.lat = exp_lat(a, b, sgn);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b0; bus.is_signed = sgn;
    bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        e = sb.pop_front();
        total++;
        if (k != e.lat) begin
          bad++; $display("FAIL %s latency got=%0d want=%0d", name, k, e.lat);
        end
        total++;
        if (bus.quotient !== e.q) begin
          bad++; $display("FAIL %s quotient got=%h want=%h", name, bus.quotient, e.q);
        end
        total++;
        if (bus.remainder !== e.r) begin
          bad++; $display("FAIL %s remainder got=%h want=%h", name, bus.remainder, e.r);
        end
        total++;
        if (bus.div_by_zero !== e.dbz) begin
          bad++; $display("FAIL %s div_by_zero got=%b want=%b", name, bus.div_by_zero, e.dbz);
        end
        total++;
        if (bus.busy !== 1'b0) begin
          bad++; $display("FAIL %s busy_at_done got=%b want=0", name, bus.busy);
        end
        last_q = e.q; last_r = e.r; last_dbz = e.dbz;
      end else begin
        if (bus.busy === 1'b1) busy_cnt++;
        if (k == poke) begin
          bus.start = 1'b1; bus.dividend = 32'd1; bus.divisor = 32'd1;
        end
      end
    end
    if (!seen) begin
      total++; bad++;
      e = sb.pop_front();
      $display("FAIL %s timeout got=no_done want=done", name);
    end else begin
      total++;
      if (busy_cnt != e.lat - 1) begin
        bad++; $display("FAIL %s busy_cycles got=%0d want=%0d", name, busy_cnt, e.lat - 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.is_signed = 1'b0;
    bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {bus.busy, bus.done, bus.div_by_zero});
    end
    total++;
    if ({bus.quotient, bus.remainder} !== 64'd0) begin
      bad++; $display("FAIL reset_data got=%h_%h want=0_0", bus.quotient, bus.remainder);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got=%b%b want=00", bus.busy, bus.done);
    end
  endtask

  task automatic test_divu();
    run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 0, "divu_100_7");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, "divu_max_1");
  endtask

  task automatic test_signed();
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0, "div_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 0, "div_7_m2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 0, "div_overflow");
  endtask

  task automatic test_div_zero();
    run_div(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b0 | 1'b1, 0, "div_5_0");
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 0, "div_m5_0");
  endtask

  task automatic test_early_out();
    run_div(32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 1'b0, 0, "small_3_10");
    run_div(32'hFFFF_FFFD, 32'd10, 1'b1, 32'd0, 32'hFFFF_FFFD, 1'b0, 0, "small_m3_10");
  endtask

  task automatic test_hold();
    int dn;
    run_div(32'd1234, 32'd10, 1'b0, 32'd123, 32'd4, 1'b0, 0, "hold_op");
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    total++;
    if (dn != 0) begin
      bad++; $display("FAIL done_pulse_width got=%0d_extra want=0", dn);
    end
    total++;
    if (bus.quotient !== last_q || bus.remainder !== last_r) begin
      bad++; $display("FAIL hold_outputs got=%h_%h want=%h_%h", bus.quotient, bus.remainder, last_q, last_r);
    end
  endtask

  task automatic test_back_to_back();
    run_div(32'd200, 32'd9, 1'b0, 32'd22, 32'd2, 1'b0, 5, "start_while_busy");
    run_div(32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0, 0, "b2b_a");
    run_div(32'd82, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd82, 1'b1, 0, "b2b_b");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r;
    logic         sgn;
    for (int i = 0; i < 8; i++) begin
      a   = $urandom;
      b   = $urandom;
      sgn = i[0];
      if (i >= 4) b = b >> $urandom_range(8, 31);
      if (b == '0) b = 32'd1;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      if (sgn) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
      run_div(a, b, sgn, q, r, 1'b0, 0, "random");
    end
  endtask

  task automatic test_cancel();
    int dn;
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL cancel_busy got=%b want=0", bus.busy);
    end
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    total++;
    if (dn != 0) begin
      bad++; $display("FAIL cancel_no_done got=%0d want=0", dn);
    end
    total++;
    if (bus.quotient !== last_q || bus.remainder !== last_r || bus.div_by_zero !== last_dbz) begin
      bad++; $display("FAIL cancel_outputs got=%h_%h want=%h_%h", bus.quotient, bus.remainder, last_q, last_r);
    end
    run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 0, "after_cancel_9_3");
  endtask

  task automatic test_async_reset();
    int dn;
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      bad++; $display("FAIL async_rst_flags got=%b want=000", {bus.busy, bus.done, bus.div_by_zero});
    end
    total++;
    if ({bus.quotient, bus.remainder} !== 64'd0) begin
      bad++; $display("FAIL async_rst_data got=%h_%h want=0_0", bus.quotient, bus.remainder);
    end
    @(negedge clk);
    rst = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
    end
    total++;
    if (dn != 0) begin
      bad++; $display("FAIL async_rst_no_resume got=%0d want=0", dn);
    end
    last_q = '0; last_r = '0; last_dbz = 1'b0;
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_early_out();
    test_hold();
    test_back_to_back();
    test_random();
    test_cancel();
    test_async_reset();
    run_div(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 0, "after_reset_50_5");
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
